mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader.sv | 241 ++++++++++++++++++++++++
 tb/tb_mem_loader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader: assembles a little-endian byte stream into 32-bit words and
// writes them to memory at consecutive addresses, keeping a running 32-bit
// checksum. When the load finishes, it writes a one-byte status word to
// address 0x400 and pulses done_o for one cycle.
//
// Optional feature: define MEM_LOADER_VERIFY_EN to add a readback pass.
// That pass reads every word back, sums the read data and compares the sum
// with the checksum. A mismatch sets error_o and makes the status byte 0xEE.
// Without the macro, WRITE goes straight to DISPLAY, error_o is tied low and
// data_in_i is ignored.
module mem_loader (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [9:0]  word_count_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        byte_ready_o,
  output logic [31:0] addr_o,
  output logic        we_o,
  output logic [31:0] data_out_o,
  input  logic [31:0] data_in_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    VERIFY  = 3'd3,
    VFLUSH  = 3'd4,
    DISPLAY = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [31:0] DISPLAY_ADDR = 32'h0000_0400;

  // Modulo-2^32 accumulate used by both the write checksum and the readback sum.
  function automatic logic [31:0] add32(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  // The status word: 0xEE on a failed readback, otherwise the checksum low byte.
  function automatic logic [31:0] display_word(input logic err, input logic [31:0] sum);
    return {24'h00_0000, (err ? 8'hEE : sum[7:0])};
  endfunction

  state_t      state_r;
  logic [9:0]  count_r;
  logic [9:0]  word_idx_r;
  logic [1:0]  byte_idx_r;
  logic [23:0] word_r;        // bytes 0..2 of the word being assembled
  logic [31:0] checksum_r;

  logic [31:0] new_sum_s;
  logic [9:0]  next_idx_s;
  logic        more_words_s;

`ifdef MEM_LOADER_VERIFY_EN
  logic [9:0]  rd_addr_r;
  logic        rd_pending_r;  // a read was issued last cycle, so data_in_i is valid
  logic [31:0] rb_sum_r;
  logic        error_r;
  logic [31:0] rb_final_s;
  logic        mismatch_s;
  logic        rd_last_s;

  assign error_o = error_r;

  // Readback accumulation and the final compare, including the word landing this cycle.
  always_comb begin
    rb_final_s = add32(rb_sum_r, data_in_i);
    mismatch_s = (rb_final_s != checksum_r);
    rd_last_s  = (rd_addr_r == (count_r - 10'd1));
  end
`else
  logic unused_data_in_s;

  assign error_o          = 1'b0;
  assign unused_data_in_s = ^data_in_i;
`endif

  // Values committed when the WRITE state retires the current word.
  always_comb begin
    new_sum_s    = add32(checksum_r, data_out_o);
    next_idx_s   = word_idx_r + 10'd1;
    more_words_s = (next_idx_s < count_r);
  end

  // Main FSM. Every output is a register, loaded on entry to the state that drives it.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= IDLE;
      count_r      <= 10'd0;
      word_idx_r   <= 10'd0;
      byte_idx_r   <= 2'd0;
      word_r       <= 24'h00_0000;
      checksum_r   <= 32'h0000_0000;
      byte_ready_o <= 1'b0;
      we_o         <= 1'b0;
      addr_o       <= 32'h0000_0000;
      data_out_o   <= 32'h0000_0000;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
      rd_addr_r    <= 10'd0;
      rd_pending_r <= 1'b0;
      rb_sum_r     <= 32'h0000_0000;
      error_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            count_r    <= word_count_i;
            word_idx_r <= 10'd0;
            byte_idx_r <= 2'd0;
            checksum_r <= 32'h0000_0000;
            busy_o     <= 1'b1;
`ifdef MEM_LOADER_VERIFY_EN
            rb_sum_r   <= 32'h0000_0000;
            error_r    <= 1'b0;
`endif
            if (word_count_i == 10'd0) begin
              // Nothing to load: only the status write happens, and it reports checksum 0.
              state_r    <= DISPLAY;
              we_o       <= 1'b1;
              addr_o     <= DISPLAY_ADDR;
              data_out_o <= display_word(1'b0, 32'h0000_0000);
            end else begin
              state_r      <= COLLECT;
              byte_ready_o <= 1'b1;
            end
          end
        end

        COLLECT: begin
          // If byte_valid_i is low, nothing changes and the load waits.
          if (byte_valid_i && byte_ready_o) begin
            if (byte_idx_r == 2'd3) begin
              // The fourth byte completes the word. Present it straight from the input.
              state_r      <= WRITE;
              byte_ready_o <= 1'b0;
              byte_idx_r   <= 2'd0;
              we_o         <= 1'b1;
              addr_o       <= {22'h00_0000, word_idx_r};
              data_out_o   <= {byte_i, word_r};
            end else begin
              byte_idx_r <= byte_idx_r + 2'd1;
              case (byte_idx_r)
                2'd0:    word_r[7:0]   <= byte_i;
                2'd1:    word_r[15:8]  <= byte_i;
                2'd2:    word_r[23:16] <= byte_i;
                default: word_r        <= word_r;
              endcase
            end
          end
        end

        WRITE: begin
          checksum_r <= new_sum_s;
          word_idx_r <= next_idx_s;
          if (more_words_s) begin
            state_r      <= COLLECT;
            byte_ready_o <= 1'b1;
            we_o         <= 1'b0;
            addr_o       <= 32'h0000_0000;
            data_out_o   <= 32'h0000_0000;
          end else begin
`ifdef MEM_LOADER_VERIFY_EN
            state_r      <= VERIFY;
            rd_addr_r    <= 10'd0;
            rd_pending_r <= 1'b0;
            we_o         <= 1'b0;
            addr_o       <= 32'h0000_0000;
            data_out_o   <= 32'h0000_0000;
`else
            state_r    <= DISPLAY;
            we_o       <= 1'b1;
            addr_o     <= DISPLAY_ADDR;
            data_out_o <= display_word(1'b0, new_sum_s);
`endif
          end
        end

`ifdef MEM_LOADER_VERIFY_EN
        VERIFY: begin
          // data_in_i belongs to the address issued on the previous cycle.
          if (rd_pending_r) begin
            rb_sum_r <= rb_final_s;
          end
          rd_pending_r <= 1'b1;
          if (rd_last_s) begin
            state_r <= VFLUSH;
            addr_o  <= 32'h0000_0000;
          end else begin
            rd_addr_r <= rd_addr_r + 10'd1;
            addr_o    <= {22'h00_0000, rd_addr_r + 10'd1};
          end
        end

        VFLUSH: begin
          rb_sum_r   <= rb_final_s;
          error_r    <= mismatch_s;
          state_r    <= DISPLAY;
          we_o       <= 1'b1;
          addr_o     <= DISPLAY_ADDR;
          data_out_o <= display_word(mismatch_s, checksum_r);
        end
`endif

        DISPLAY: begin
          state_r    <= DONE;
          we_o       <= 1'b0;
          addr_o     <= 32'h0000_0000;
          data_out_o <= 32'h0000_0000;
          done_o     <= 1'b1;
        end

        DONE: begin
          state_r <= IDLE;
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
        end

        default: begin
          state_r      <= IDLE;
          byte_ready_o <= 1'b0;
          we_o         <= 1'b0;
          addr_o       <= 32'h0000_0000;
          data_out_o   <= 32'h0000_0000;
          busy_o       <= 1'b0;
          done_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed testbench for mem_loader. The memory model uses a synchronous
// read, so data_in_i arrives one cycle after addr_o. A monitor running on the
// falling edge records data writes, status writes and done pulses.
module tb_mem_loader;

  logic        clk;
  logic        reset_i;
  logic        start_i;
  logic [9:0]  word_count_i;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o;
  logic [31:0] addr_o;
  logic        we_o;
  logic [31:0] data_out_o;
  logic [31:0] data_in_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  int checks;
  int errors;

  logic [31:0] mem [0:1023];
  logic        corrupt;

  logic [31:0] wr_addr [0:15];
  logic [31:0] wr_data [0:15];
  int          wr_n;
  int          disp_n;
  logic [31:0] disp_data;
  int          done_n;

  mem_loader dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .word_count_i (word_count_i),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .byte_ready_o (byte_ready_o),
    .addr_o       (addr_o),
    .we_o         (we_o),
    .data_out_o   (data_out_o),
    .data_in_i    (data_in_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model. When corrupt is set, a read of word 1 returns a flipped LSB.
  always @(posedge clk) begin
    if (we_o && (addr_o < 32'd1024)) mem[addr_o[9:0]] <= data_out_o;
    data_in_i <= mem[addr_o[9:0]] ^ ((corrupt && (addr_o == 32'd1)) ? 32'h0000_0001 : 32'h0000_0000);
  end

  // Write and done monitor.
  always @(negedge clk) begin
    if (we_o) begin
      if (addr_o == 32'h0000_0400) begin
        disp_n    = disp_n + 1;
        disp_data = data_out_o;
      end else begin
        if (wr_n < 16) begin
          wr_addr[wr_n] = addr_o;
          wr_data[wr_n] = data_out_o;
        end
        wr_n = wr_n + 1;
      end
    end
    if (done_o) done_n = done_n + 1;
  end

  task automatic clear_log;
    wr_n   = 0;
    disp_n = 0;
    done_n = 0;
    disp_data = 32'hFFFF_FFFF;
  endtask

  task automatic start_load(input logic [9:0] cnt);
    word_count_i = cnt;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid_i = 1'b1;
    byte_i = b;
    while (!byte_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!byte_ready_o) begin
      errors++;
      $display("FAIL byte_ready_timeout: got %0b expected 1", byte_ready_o);
    end
    @(negedge clk);
    byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (done_n == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_n == 0) begin
      errors++;
      $display("FAIL done_timeout: got no done_o expected a pulse");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_two_word_load(input logic exp_err, input logic [31:0] exp_disp);
    checks++;
    if (wr_n !== 2) begin errors++; $display("FAIL write_count: got %0d expected 2", wr_n); end
    checks++;
    if (wr_addr[0] !== 32'd0 || wr_data[0] !== 32'h4433_2211) begin
      errors++; $display("FAIL word0: got [%h]=%h expected [0]=44332211", wr_addr[0], wr_data[0]);
    end
    checks++;
    if (wr_addr[1] !== 32'd1 || wr_data[1] !== 32'h8877_6655) begin
      errors++; $display("FAIL word1: got [%h]=%h expected [1]=88776655", wr_addr[1], wr_data[1]);
    end
    checks++;
    if (disp_n !== 1 || disp_data !== exp_disp) begin
      errors++; $display("FAIL display: got %0d writes data %h expected 1 write data %h", disp_n, disp_data, exp_disp);
    end
    checks++;
    if (done_n !== 1) begin errors++; $display("FAIL done_pulses: got %0d expected 1", done_n); end
    checks++;
    if (error_o !== exp_err) begin errors++; $display("FAIL error_o: got %0b expected %0b", error_o, exp_err); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %0b expected 0", busy_o); end
  endtask

  task automatic test_reset;
    reset_i = 1'b0;
    #3;
    reset_i = 1'b1;
    #2;
    checks++;
    if ({byte_ready_o, we_o, busy_o, done_o, error_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {byte_ready_o, we_o, busy_o, done_o, error_o});
    end
    checks++;
    if (addr_o !== 32'd0 || data_out_o !== 32'd0) begin
      errors++; $display("FAIL reset_bus: got addr %h data %h expected 0 0", addr_o, data_out_o);
    end
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    clear_log();
    start_load(10'd2);
    checks++;
    if (busy_o !== 1'b1 || byte_ready_o !== 1'b1) begin
      errors++; $display("FAIL collect_entry: got busy %0b ready %0b expected 1 1", busy_o, byte_ready_o);
    end
    send_word(32'h4433_2211);
    send_word(32'h8877_6655);
    wait_done();
    check_two_word_load(1'b0, 32'h0000_0066);
  endtask

  task automatic test_verify_error;
    corrupt = 1'b1;
    clear_log();
    start_load(10'd2);
    send_word(32'h4433_2211);
    send_word(32'h8877_6655);
    wait_done();
    check_two_word_load(1'b1, 32'h0000_00EE);
    corrupt = 1'b0;
  endtask

  task automatic test_zero_count;
    int got;
    clear_log();
    got = 0;
    word_count_i = 10'd0;
    start_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (done_o && got == 0) got = k;
    end
    checks++;
    if (got == 0 || got > 3) begin errors++; $display("FAIL zero_done_latency: got %0d cycles expected 1..3", got); end
    checks++;
    if (wr_n !== 0) begin errors++; $display("FAIL zero_data_writes: got %0d expected 0", wr_n); end
    checks++;
    if (disp_n !== 1 || disp_data !== 32'h0000_0000) begin
      errors++; $display("FAIL zero_display: got %0d writes data %h expected 1 write data 00000000", disp_n, disp_data);
    end
    checks++;
    if (error_o !== 1'b0) begin errors++; $display("FAIL zero_error_clear: got %0b expected 0", error_o); end
  endtask

  task automatic test_gaps;
    clear_log();
    start_load(10'd1);
    send_byte(8'hAA); @(negedge clk);
    send_byte(8'hBB); @(negedge clk);
    send_byte(8'hCC); @(negedge clk);
    send_byte(8'hDD); @(negedge clk);
    wait_done();
    checks++;
    if (wr_n !== 1 || wr_addr[0] !== 32'd0 || wr_data[0] !== 32'hDDCC_BBAA) begin
      errors++; $display("FAIL gap_word: got %0d writes [%h]=%h expected 1 write [0]=DDCCBBAA", wr_n, wr_addr[0], wr_data[0]);
    end
    checks++;
    if (disp_data !== 32'h0000_00AA) begin errors++; $display("FAIL gap_display: got %h expected 000000AA", disp_data); end
  endtask

  task automatic test_reset_midload;
    clear_log();
    start_load(10'd1);
    send_byte(8'h99);
    send_byte(8'h98);
    reset_i = 1'b1;
    #1;
    checks++;
    if ({byte_ready_o, we_o, busy_o, done_o, error_o} !== 5'b0 || addr_o !== 32'd0 || data_out_o !== 32'd0) begin
      errors++; $display("FAIL midload_reset: got flags %b addr %h data %h expected all 0",
                         {byte_ready_o, we_o, busy_o, done_o, error_o}, addr_o, data_out_o);
    end
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_n !== 0 || disp_n !== 0 || done_n !== 0) begin
      errors++; $display("FAIL abandoned_load: got writes %0d display %0d done %0d expected 0 0 0", wr_n, disp_n, done_n);
    end
    clear_log();
    start_load(10'd1);
    send_word(32'h0403_0201);
    wait_done();
    checks++;
    if (wr_n !== 1 || wr_addr[0] !== 32'd0 || wr_data[0] !== 32'h0403_0201) begin
      errors++; $display("FAIL fresh_load: got %0d writes [%h]=%h expected 1 write [0]=04030201", wr_n, wr_addr[0], wr_data[0]);
    end
    checks++;
    if (disp_data !== 32'h0000_0001) begin errors++; $display("FAIL fresh_display: got %h expected 00000001", disp_data); end
  endtask

  task automatic test_ignore_start;
    clear_log();
    start_load(10'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    word_count_i = 10'd5;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    word_count_i = 10'd2;
    checks++;
    if (busy_o !== 1'b1 || byte_ready_o !== 1'b1) begin
      errors++; $display("FAIL start_in_collect: got busy %0b ready %0b expected 1 1", busy_o, byte_ready_o);
    end
    send_byte(8'h33);
    send_byte(8'h44);
    send_word(32'h8877_6655);
    wait_done();
    check_two_word_load(1'b0, 32'h0000_0066);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    corrupt = 1'b0;
    start_i = 1'b0;
    word_count_i = 10'd0;
    byte_valid_i = 1'b0;
    byte_i = 8'h00;
    clear_log();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;

    test_reset();
    test_basic();
`ifdef MEM_LOADER_VERIFY_EN
    test_verify_error();
`endif
    test_zero_count();
    test_gaps();
    test_reset_midload();
    test_ignore_start();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
